// File: rtl/uart_word_packer_if.sv
// Write-side FIFO bus between the UART word packer and the DDR3 write FIFO.
// The packer is the master: it drives the write strobe, word and partial flag,
// and observes the FIFO full flag and fill count.
interface uart_word_packer_if #(
    parameter int OUT_W = 128,
    parameter int CNT_W = 5
);
    logic             wfifo_wr_en;
    logic [OUT_W-1:0] wfifo_wr_data;
    logic             wfifo_wr_partial;
    logic             wfifo_full;
    logic [CNT_W-1:0] wfifo_wr_cnt;

    modport master (
        output wfifo_wr_en,
        output wfifo_wr_data,
        output wfifo_wr_partial,
        input  wfifo_full,
        input  wfifo_wr_cnt
    );

    modport slave (
        input  wfifo_wr_en,
        input  wfifo_wr_data,
        input  wfifo_wr_partial,
        output wfifo_full,
        output wfifo_wr_cnt
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs received UART bytes into OUT_W-bit words for the DDR3 write FIFO.
// Partial words are padded with PAD_BYTE and emitted on flush or idle timeout.
// Words that meet a full FIFO are dropped and flagged in a sticky error bit.
module uart_word_packer #(
    parameter int         OUT_W       = 128,
    parameter bit         MSB_FIRST   = 1'b1,
    parameter int         TIMEOUT_CYC = 0,
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         CNT_W       = 5,
    parameter int         TRIG_LVL    = 16
) (
    input  logic                wfifo_wr_clk,
    input  logic                s_rst_n,
    input  logic [7:0]          uart_rx_data,
    input  logic                uart_rx_vld,
    input  logic                flush,
    input  logic                err_clr,
    uart_word_packer_if.master  wfifo,
    output logic                wr_trig,
    output logic                overflow_err
);
    localparam int               NB       = OUT_W / 8;
    localparam int               BC_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(NB - 1);
    localparam logic [OUT_W-1:0] PAD_WORD = {NB{PAD_BYTE}};
    localparam logic [16:0]      TMO_LIM  = 17'(TIMEOUT_CYC);
    // Widened so a threshold above the counter range simply never matches.
    localparam logic [32:0]      TRIG_THR = 33'(TRIG_LVL);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t           state_q, state_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0]      idle_cnt_q, idle_cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             wr_en_q, wr_en_d;
    logic [OUT_W-1:0] wr_data_q, wr_data_d;
    logic             wr_partial_q, wr_partial_d;
    logic             wr_trig_q, wr_trig_d;
    logic             overflow_err_q, overflow_err_d;

    logic             emit;
    logic             emit_partial;
    logic [OUT_W-1:0] emit_word;
    logic [OUT_W-1:0] acc_new;

    // Drop byte b into the lane that byte position k maps to.
    function automatic logic [OUT_W-1:0] place_byte(input logic [OUT_W-1:0] acc,
                                                    input logic [BC_W-1:0]  k,
                                                    input logic [7:0]       b);
        logic [OUT_W-1:0] w;
        int               lane;
        w    = acc;
        lane = MSB_FIRST ? (NB - 1 - int'(k)) : int'(k);
        w[lane*8 +: 8] = b;
        return w;
    endfunction

    // Next-state logic: byte accumulation, emit decision, error and trigger.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        acc_d        = acc_q;
        emit         = 1'b0;
        emit_partial = 1'b0;
        emit_word    = acc_q;
        acc_new      = place_byte(acc_q, byte_cnt_q, uart_rx_data);

        if (uart_rx_vld) begin
            idle_cnt_d = '0;
            if (byte_cnt_q == LAST_IDX) begin
                // Completing byte wins over a simultaneous flush: one full word.
                emit      = 1'b1;
                emit_word = acc_new;
            end else begin
                acc_d      = acc_new;
                byte_cnt_d = byte_cnt_q + 1'b1;
                state_d    = S_FILL;
                if (flush) begin
                    emit         = 1'b1;
                    emit_partial = 1'b1;
                    emit_word    = acc_new;
                end
            end
        end else if (state_q == S_FILL) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
            if (flush) begin
                emit         = 1'b1;
                emit_partial = 1'b1;
            end else if (TIMEOUT_CYC != 0 && ({1'b0, idle_cnt_q} + 17'd1) == TMO_LIM) begin
                emit         = 1'b1;
                emit_partial = 1'b1;
            end
        end

        if (emit) begin
            acc_d      = PAD_WORD;
            byte_cnt_d = '0;
            idle_cnt_d = '0;
            state_d    = S_IDLE;
        end

        wr_en_d        = emit & ~wfifo.wfifo_full;
        wr_data_d      = wr_en_d ? emit_word : wr_data_q;
        wr_partial_d   = wr_en_d & emit_partial;
        overflow_err_d = (emit & wfifo.wfifo_full) | (overflow_err_q & ~err_clr);
        wr_trig_d      = (33'(wfifo.wfifo_wr_cnt) >= TRIG_THR);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge wfifo_wr_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            acc_q          <= PAD_WORD;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_partial_q   <= 1'b0;
            wr_trig_q      <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            acc_q          <= acc_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            wr_partial_q   <= wr_partial_d;
            wr_trig_q      <= wr_trig_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign wfifo.wfifo_wr_en      = wr_en_q;
    assign wfifo.wfifo_wr_data    = wr_data_q;
    assign wfifo.wfifo_wr_partial = wr_partial_q;
    assign wr_trig                = wr_trig_q;
    assign overflow_err           = overflow_err_q;
endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer: two instances (128-bit MSB-first with timeout,
// 32-bit LSB-first with 0xEE padding) driven by directed and random steps and
// compared every cycle against a byte-list reference model.
module tb_uart_word_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_data, b_data;
    logic       a_vld, b_vld, a_flush, b_flush, a_clr, b_clr;
    logic       a_trig, a_ovf, b_trig, b_ovf;

    uart_word_packer_if #(.OUT_W(128), .CNT_W(5)) ifa ();
    uart_word_packer_if #(.OUT_W(32),  .CNT_W(5)) ifb ();

    uart_word_packer #(
        .OUT_W(128), .MSB_FIRST(1'b1), .TIMEOUT_CYC(10),
        .PAD_BYTE(8'h00), .CNT_W(5), .TRIG_LVL(16)
    ) dut_a (
        .wfifo_wr_clk(clk), .s_rst_n(rst_n),
        .uart_rx_data(a_data), .uart_rx_vld(a_vld), .flush(a_flush),
        .err_clr(a_clr), .wfifo(ifa.master), .wr_trig(a_trig), .overflow_err(a_ovf)
    );

    uart_word_packer #(
        .OUT_W(32), .MSB_FIRST(1'b0), .TIMEOUT_CYC(0),
        .PAD_BYTE(8'hEE), .CNT_W(5), .TRIG_LVL(40)
    ) dut_b (
        .wfifo_wr_clk(clk), .s_rst_n(rst_n),
        .uart_rx_data(b_data), .uart_rx_vld(b_vld), .flush(b_flush),
        .err_clr(b_clr), .wfifo(ifb.master), .wr_trig(b_trig), .overflow_err(b_ovf)
    );

    // Reference model: per instance, a list of bytes received for the open word.
    int         m_nb   [2] = '{16, 4};
    int         m_msb  [2] = '{1, 0};
    int         m_tmo  [2] = '{10, 0};
    logic [7:0] m_pad  [2] = '{8'h00, 8'hEE};
    int         m_trl  [2] = '{16, 40};
    logic [7:0] m_buf  [2][16];
    int         m_n    [2];
    int         m_idle [2];
    logic         e_en   [2];
    logic         e_part [2];
    logic         e_trig [2];
    logic         e_ovf  [2];
    logic [127:0] e_data [2];

    int n_asrt = 0;
    int n_fail = 0;

    function automatic logic [127:0] build_word(int i);
        logic [127:0] w;
        int lane;
        w = '0;
        for (int k = 0; k < m_nb[i]; k++) begin
            lane = (m_msb[i] != 0) ? (m_nb[i] - 1 - k) : k;
            w[lane*8 +: 8] = (k < m_n[i]) ? m_buf[i][k] : m_pad[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_idle[i] = 0;
            e_en[i] = 1'b0; e_part[i] = 1'b0; e_trig[i] = 1'b0;
            e_ovf[i] = 1'b0; e_data[i] = '0;
        end
    endtask

    task automatic model_step(int i, logic v, logic [7:0] d, logic f,
                              logic full, logic [4:0] cnt, logic clr);
        logic emit, part;
        emit = 1'b0; part = 1'b0;
        if (v) begin
            m_buf[i][m_n[i]] = d;
            m_n[i]++;
            m_idle[i] = 0;
            if (m_n[i] == m_nb[i]) emit = 1'b1;
            else if (f) begin emit = 1'b1; part = 1'b1; end
        end else if (m_n[i] > 0) begin
            m_idle[i]++;
            if (f) begin emit = 1'b1; part = 1'b1; end
            else if (m_tmo[i] != 0 && m_idle[i] == m_tmo[i]) begin emit = 1'b1; part = 1'b1; end
        end
        e_en[i] = 1'b0; e_part[i] = 1'b0;
        if (emit) begin
            if (full) e_ovf[i] = 1'b1;
            else begin
                e_en[i] = 1'b1; e_part[i] = part; e_data[i] = build_word(i);
            end
            m_n[i] = 0; m_idle[i] = 0;
        end
        if (!(emit && full) && clr) e_ovf[i] = 1'b0;
        e_trig[i] = (m_trl[i] <= 31) && (int'(cnt) >= m_trl[i]);
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("A_wr_en",   128'(ifa.wfifo_wr_en),      128'(e_en[0]));
        chk("A_partial", 128'(ifa.wfifo_wr_partial), 128'(e_part[0]));
        chk("A_data",    ifa.wfifo_wr_data,          e_data[0]);
        chk("A_trig",    128'(a_trig),               128'(e_trig[0]));
        chk("A_ovf",     128'(a_ovf),                128'(e_ovf[0]));
        chk("B_wr_en",   128'(ifb.wfifo_wr_en),      128'(e_en[1]));
        chk("B_partial", 128'(ifb.wfifo_wr_partial), 128'(e_part[1]));
        chk("B_data",    128'(ifb.wfifo_wr_data),    e_data[1]);
        chk("B_trig",    128'(b_trig),               128'(e_trig[1]));
        chk("B_ovf",     128'(b_ovf),                128'(e_ovf[1]));
    endtask

    task automatic tick();
        model_step(0, a_vld, a_data, a_flush, ifa.wfifo_full, ifa.wfifo_wr_cnt, a_clr);
        model_step(1, b_vld, b_data, b_flush, ifb.wfifo_full, ifb.wfifo_wr_cnt, b_clr);
        @(posedge clk);
        #1;
        check_all();
        a_vld = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
        b_vld = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
    endtask

    task automatic a_byte(logic [7:0] d);
        a_vld = 1'b1; a_data = d; tick();
    endtask

    task automatic b_byte(logic [7:0] d);
        b_vld = 1'b1; b_data = d; tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_vld = 0; a_flush = 0; a_clr = 0; a_data = '0;
        b_vld = 0; b_flush = 0; b_clr = 0; b_data = '0;
        ifa.wfifo_full = 0; ifa.wfifo_wr_cnt = '0;
        ifb.wfifo_full = 0; ifb.wfifo_wr_cnt = '0;
        model_reset();
        #2;
        check_all();
        #10 rst_n = 1'b1;

        // Full 128-bit word from bytes 0x00..0x0F
        for (int k = 0; k < 16; k++) a_byte(8'(k));
        chk("full_word_const", ifa.wfifo_wr_data, 128'h000102030405060708090A0B0C0D0E0F);
        chk("full_word_en", 128'(ifa.wfifo_wr_en), 128'd1);
        tick();

        // LSB-first lane order and padded flush on the 32-bit instance
        b_byte(8'hA1); b_byte(8'hB2); b_byte(8'hC3); b_byte(8'hD4);
        chk("lsb_word_const", 128'(ifb.wfifo_wr_data), 128'hD4C3B2A1);
        b_byte(8'h11); b_byte(8'h22);
        b_flush = 1'b1; tick();
        chk("pad_word_const", 128'(ifb.wfifo_wr_data), 128'hEEEE2211);
        chk("pad_word_partial", 128'(ifb.wfifo_wr_partial), 128'd1);

        // Timeout after 10 idle cycles, then restart of the idle count
        a_byte(8'h31); a_byte(8'h32); a_byte(8'h33);
        repeat (9) tick();
        chk("tmo_early", 128'(ifa.wfifo_wr_en), 128'd0);
        tick();
        chk("tmo_pulse", 128'(ifa.wfifo_wr_en), 128'd1);
        chk("tmo_partial", 128'(ifa.wfifo_wr_partial), 128'd1);
        a_byte(8'h41); a_byte(8'h42); a_byte(8'h43);
        repeat (4) tick();
        a_byte(8'h44);
        repeat (9) tick();
        chk("tmo_restart_early", 128'(ifa.wfifo_wr_en), 128'd0);
        tick();
        chk("tmo_restart_pulse", 128'(ifa.wfifo_wr_en), 128'd1);

        // Completing byte with flush, back-to-back byte, flush while idle
        for (int k = 0; k < 15; k++) a_byte(8'(8'h60 + k));
        a_vld = 1'b1; a_data = 8'h6F; a_flush = 1'b1; tick();
        chk("simul_partial", 128'(ifa.wfifo_wr_partial), 128'd0);
        a_byte(8'h5A);
        chk("simul_no_extra", 128'(ifa.wfifo_wr_en), 128'd0);
        for (int k = 0; k < 15; k++) a_byte(8'(k + 1));
        chk("next_first_lane", 128'(ifa.wfifo_wr_data[127:120]), 128'h5A);
        a_flush = 1'b1; tick();
        a_flush = 1'b1; tick();
        chk("idle_flush", 128'(ifa.wfifo_wr_en), 128'd0);

        // Overflow: drop, sticky flag, clear, set-wins-over-clear
        for (int k = 0; k < 15; k++) a_byte(8'hC0);
        ifa.wfifo_full = 1'b1; a_byte(8'hC1); ifa.wfifo_full = 1'b0;
        chk("ovf_set", 128'(a_ovf), 128'd1);
        repeat (3) tick();
        a_clr = 1'b1; tick();
        chk("ovf_clr", 128'(a_ovf), 128'd0);
        for (int k = 0; k < 15; k++) a_byte(8'hD0);
        ifa.wfifo_full = 1'b1; a_clr = 1'b1; a_byte(8'hD1); ifa.wfifo_full = 1'b0;
        chk("ovf_set_wins", 128'(a_ovf), 128'd1);

        // Burst trigger threshold and out-of-range threshold
        ifa.wfifo_wr_cnt = 5'd15; ifb.wfifo_wr_cnt = 5'd31; tick();
        ifa.wfifo_wr_cnt = 5'd16; tick();
        chk("trig_hi", 128'(a_trig), 128'd1);
        ifa.wfifo_wr_cnt = 5'd15; tick();
        chk("trig_lo", 128'(a_trig), 128'd0);

        // Asynchronous reset in the middle of a word
        ifa.wfifo_wr_cnt = 5'd20; tick();
        for (int k = 0; k < 7; k++) a_byte(8'h99);
        ifa.wfifo_wr_cnt = 5'd0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) a_byte(8'($urandom));
        tick();

        // Random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            a_vld = ($urandom_range(0, 3) != 0); a_data = 8'($urandom);
            a_flush = ($urandom_range(0, 15) == 0); a_clr = ($urandom_range(0, 15) == 0);
            ifa.wfifo_full = ($urandom_range(0, 7) == 0); ifa.wfifo_wr_cnt = 5'($urandom);
            b_vld = ($urandom_range(0, 2) != 0); b_data = 8'($urandom);
            b_flush = ($urandom_range(0, 7) == 0); b_clr = ($urandom_range(0, 15) == 0);
            ifb.wfifo_full = ($urandom_range(0, 7) == 0); ifb.wfifo_wr_cnt = 5'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a_vld = 1'b0; b_vld = 1'b0;
                repeat ($urandom_range(1, 14)) tick();
            end else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
